// File: rtl/sfifo_arbiter_if.sv
// Bus between the producer/consumer/sfifo side and the sfifo_arbiter.
// The arbiter connects through the slave modport.
interface sfifo_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  rd_req;
  logic                  rd_ack;
  logic                  fifo_write_enable;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  fifo_read_enable;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OCC_W-1:0]      occupancy;
  logic                  err;

  modport master (
    output req, wdata, rd_req, fifo_full, fifo_empty,
    input  gnt, rd_ack, fifo_write_enable, fifo_data_in, fifo_read_enable,
           occupancy, err
  );

  modport slave (
    input  req, wdata, rd_req, fifo_full, fifo_empty,
    output gnt, rd_ack, fifo_write_enable, fifo_data_in, fifo_read_enable,
           occupancy, err
  );
endinterface

// File: rtl/sfifo_arbiter.sv
// Round-robin write arbiter and read gate in front of the 8-deep sfifo.
// Tracks its own occupancy so the FIFO is never written full or read empty.
module sfifo_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  sfifo_arbiter_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  gnt_c;
  logic [IDX_W-1:0] win_idx;
  logic             accept;
  logic             eligible;
  logic             rd_ack_c;
  int unsigned      idx;

  // Search from last+1 upward, wrapping; the first requester wins if a slot is free.
  always_comb begin
    gnt_c    = '0;
    win_idx  = '0;
    accept   = 1'b0;
    idx      = 0;
    eligible = reset && (occ_q < OCC_W'(DEPTH));
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (eligible && !accept && bus.req[IDX_W'(idx)]) begin
        accept                = 1'b1;
        win_idx               = IDX_W'(idx);
        gnt_c[IDX_W'(idx)]    = 1'b1;
      end
    end
  end

  // Only words already stored in the FIFO are readable; the in-flight write is excluded.
  always_comb begin
    rd_ack_c = reset && bus.rd_req && ((occ_q - OCC_W'(pend_q)) != '0);
    occ_d    = occ_q + OCC_W'(accept) - OCC_W'(rd_ack_c);
    last_d   = accept ? win_idx : last_q;
    pend_d   = accept;
    data_d   = data_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) data_d = bus.wdata[i*WIDTH +: WIDTH];
    end
    err_d    = err_q | (pend_q & bus.fifo_full) | (rd_ack_c & bus.fifo_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q  <= '0;
      last_q <= IDX_W'(NREQ - 1);
      pend_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      last_q <= last_d;
      pend_q <= pend_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.gnt               = gnt_c;
  assign bus.rd_ack            = rd_ack_c;
  assign bus.fifo_read_enable  = rd_ack_c;
  assign bus.fifo_write_enable = pend_q;
  assign bus.fifo_data_in      = data_q;
  assign bus.occupancy         = occ_q;
  assign bus.err               = err_q;
endmodule
